// File: rtl/prewish_debounce_sched_if.sv
// Report/command handshake bundle for the prewish debounce scheduler.
// The controller side is the master; the scheduler is the slave.
interface prewish_debounce_sched_if;
  logic       stb_i;
  logic [7:0] dat_i;
  logic       stb_o;
  logic [7:0] dat_o;
  logic       ack_i;

  modport master (output stb_i, dat_i, ack_i, input stb_o, dat_o);
  modport slave  (input stb_i, dat_i, ack_i, output stb_o, dat_o);
endinterface

// File: rtl/prewish_debounce_sched.sv
// Shared debounce scheduler: one compare/count engine walks all button channels per tick.
// Optional debug heartbeat on o_alive is enabled with `define PREWISH_DBSCHED_ALIVE_EN.
module prewish_debounce_sched #(
  parameter int         NUM_BTN        = 4,
  parameter int         TICK_BITS      = 20,
  parameter logic [3:0] DB_LEN_DEFAULT = 4'd4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_BTN-1:0]        iN_button,
  prewish_debounce_sched_if.slave   bus,
  output logic                      o_alive
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                   state_q;
  logic [2:0]               ch_q;

  logic [NUM_BTN-1:0]       sync1_q, sync1_d, sync2_q, sync2_d, sample;
  logic [TICK_BITS-1:0]     tick_ct_q, tick_ct_d;
  logic                     tick;

  logic [NUM_BTN-1:0]       stable_q, stable_d;
  logic [NUM_BTN-1:0][3:0]  cnt_q, cnt_d;
  logic [NUM_BTN-1:0]       pend_q, pend_d, pend_set, pend_clr;
  logic [NUM_BTN-1:0]       mask_q, mask_d;
  logic [3:0]               db_len_q, db_len_d;
  logic                     stat_pend_q, stat_pend_d, stat_set, stat_clr;

  logic                     stb_o_q, stb_o_d;
  logic [7:0]               dat_o_q, dat_o_d;
  logic                     rpt_stat_q, rpt_stat_d;
  logic [2:0]               rpt_ch_q, rpt_ch_d;
  logic [2:0]               last_q, last_d;

  logic                     found;
  logic [2:0]               gnt;
  logic                     gnt_stable;
  logic [7:0]               stat_byte;

  assign sample = ~sync2_q;
  assign tick   = &tick_ct_q;

  // Channel walk: enter SCAN on a tick, step one channel per cycle, then idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= SCAN;
            ch_q    <= 3'd0;
          end
        end
        SCAN: begin
          if (ch_q == 3'(NUM_BTN - 1)) begin
            state_q <= IDLE;
            ch_q    <= 3'd0;
          end else begin
            ch_q <= ch_q + 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ch_q    <= 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    sync1_d     = iN_button;
    sync2_d     = sync1_q;
    tick_ct_d   = tick_ct_q + TICK_BITS'(1);
    stable_d    = stable_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    db_len_d    = db_len_q;
    stb_o_d     = stb_o_q;
    dat_o_d     = dat_o_q;
    rpt_stat_d  = rpt_stat_q;
    rpt_ch_d    = rpt_ch_q;
    last_d      = last_q;
    pend_set    = '0;
    pend_clr    = '0;
    stat_set    = 1'b0;
    stat_clr    = 1'b0;
    found       = 1'b0;
    gnt         = 3'd0;
    gnt_stable  = 1'b0;
    stat_byte   = '0;
    stat_byte[NUM_BTN-1:0] = stable_q;
    stat_byte[7]           = 1'b1;

    // Shared engine: only the channel selected by ch_q is evaluated this cycle.
    for (int i = 0; i < NUM_BTN; i++) begin
      if (state_q == SCAN && ch_q == 3'(i)) begin
        if (sample[i] == stable_q[i]) begin
          cnt_d[i] = 4'd0;
        end else if (({1'b0, cnt_q[i]} + 5'd1) >= {1'b0, db_len_q}) begin
          stable_d[i] = sample[i];
          cnt_d[i]    = 4'd0;
          pend_set[i] = ~mask_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end

    if (bus.stb_i) begin
      case (bus.dat_i[7:6])
        2'b00:   db_len_d = (bus.dat_i[3:0] == 4'd0) ? 4'd1 : bus.dat_i[3:0];
        2'b01:   mask_d   = bus.dat_i[NUM_BTN-1:0];
        2'b10:   stat_set = 1'b1;
        default: ;
      endcase
    end

    // Round-robin search begins just after the last channel that was reported.
    for (int off = 1; off <= NUM_BTN; off++) begin
      for (int j = 0; j < NUM_BTN; j++) begin
        if (!found && pend_q[j] && j == ((int'(last_q) + off) % NUM_BTN)) begin
          found      = 1'b1;
          gnt        = 3'(j);
          gnt_stable = stable_q[j];
        end
      end
    end

    if (stb_o_q) begin
      if (bus.ack_i) begin
        stb_o_d = 1'b0;
        if (rpt_stat_q) begin
          stat_clr = 1'b1;
        end else begin
          for (int j = 0; j < NUM_BTN; j++) begin
            if (rpt_ch_q == 3'(j)) pend_clr[j] = 1'b1;
          end
        end
      end
    end else if (stat_pend_q) begin
      stb_o_d    = 1'b1;
      rpt_stat_d = 1'b1;
      dat_o_d    = stat_byte;
    end else if (found) begin
      stb_o_d    = 1'b1;
      rpt_stat_d = 1'b0;
      rpt_ch_d   = gnt;
      last_d     = gnt;
      dat_o_d    = {1'b0, gnt_stable, 3'b000, gnt};
    end

    // A set landing in the same cycle as the ack clear survives, so the item is re-reported.
    pend_d      = (pend_q & ~pend_clr) | pend_set;
    stat_pend_d = (stat_pend_q & ~stat_clr) | stat_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      tick_ct_q   <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      db_len_q    <= DB_LEN_DEFAULT;
      stat_pend_q <= 1'b0;
      stb_o_q     <= 1'b0;
      dat_o_q     <= 8'h00;
      rpt_stat_q  <= 1'b0;
      rpt_ch_q    <= 3'd0;
      last_q      <= 3'(NUM_BTN - 1);
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      tick_ct_q   <= tick_ct_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      db_len_q    <= db_len_d;
      stat_pend_q <= stat_pend_d;
      stb_o_q     <= stb_o_d;
      dat_o_q     <= dat_o_d;
      rpt_stat_q  <= rpt_stat_d;
      rpt_ch_q    <= rpt_ch_d;
      last_q      <= last_d;
    end
  end

  assign bus.stb_o = stb_o_q;
  assign bus.dat_o = dat_o_q;

`ifdef PREWISH_DBSCHED_ALIVE_EN
  logic alive_q, alive_d;

  always_comb begin
    alive_d = alive_q;
    if (tick) alive_d = ~alive_q;
  end

  always_ff @(posedge clk) begin
    if (reset) alive_q <= 1'b0;
    else       alive_q <= alive_d;
  end

  assign o_alive = alive_q;
`else
  assign o_alive = 1'b0;
`endif

endmodule
